// File: rtl/bcd_disp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_disp_pkg
// Description : Shared types, constants and helpers for the BCD display scan
//               block: conversion FSM state type, active-low segment patterns,
//               digit/step counts, segment decoder and one double-dabble step.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_disp_pkg;

    typedef enum logic [1:0] {
        S_SAMPLE = 2'd0,
        S_SHIFT  = 2'd1,
        S_LOAD   = 2'd2
    } state_t;

    localparam int NUM_DIGITS  = 4;
    localparam int SHIFT_STEPS = 6;

    // Segment patterns, bit order {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] c_SEG_0     = 7'b1000000;
    localparam logic [6:0] c_SEG_1     = 7'b1111001;
    localparam logic [6:0] c_SEG_2     = 7'b0100100;
    localparam logic [6:0] c_SEG_3     = 7'b0110000;
    localparam logic [6:0] c_SEG_4     = 7'b0011001;
    localparam logic [6:0] c_SEG_5     = 7'b0010010;
    localparam logic [6:0] c_SEG_6     = 7'b0000010;
    localparam logic [6:0] c_SEG_7     = 7'b1111000;
    localparam logic [6:0] c_SEG_8     = 7'b0000000;
    localparam logic [6:0] c_SEG_9     = 7'b0010000;
    localparam logic [6:0] c_SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] w_seg;
        case (digit)
            4'd0:    w_seg = c_SEG_0;
            4'd1:    w_seg = c_SEG_1;
            4'd2:    w_seg = c_SEG_2;
            4'd3:    w_seg = c_SEG_3;
            4'd4:    w_seg = c_SEG_4;
            4'd5:    w_seg = c_SEG_5;
            4'd6:    w_seg = c_SEG_6;
            4'd7:    w_seg = c_SEG_7;
            4'd8:    w_seg = c_SEG_8;
            4'd9:    w_seg = c_SEG_9;
            default: w_seg = c_SEG_BLANK;
        endcase
        return w_seg;
    endfunction

    // One double-dabble iteration on {tens, units, binary[5:0]}:
    // correct any BCD nibble >= 5 by adding 3, then shift the whole word left.
    // Tens never exceeds 6 for a 6-bit input, so nothing is lost off the top.
    function automatic logic [13:0] dd_step(input logic [13:0] v);
        logic [13:0] w_t;
        w_t = v;
        if (w_t[9:6] >= 4'd5) begin
            w_t[9:6] = w_t[9:6] + 4'd3;
        end
        if (w_t[13:10] >= 4'd5) begin
            w_t[13:10] = w_t[13:10] + 4'd3;
        end
        return {w_t[12:0], 1'b0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd6.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd6
// Description : Free-running double-dabble converter for two 6-bit values.
//               S_SAMPLE (1 cycle) latches both inputs, S_SHIFT (6 cycles)
//               runs the add-3/shift steps, S_LOAD (1 cycle) presents the
//               finished BCD with o_load high. Period is 8 cycles.
// Ports       : clk, reset      - clock, synchronous active-high reset
//               i_sec, i_min    - binary values to convert (0..63)
//               o_load          - high during the S_LOAD cycle
//               o_sec_bcd       - {tens, units} of i_sec, valid with o_load
//               o_min_bcd       - {tens, units} of i_min, valid with o_load
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd6
    import bcd_disp_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] i_sec,
    input  logic [5:0] i_min,
    output logic       o_load,
    output logic [7:0] o_sec_bcd,
    output logic [7:0] o_min_bcd
);

    localparam logic [2:0] c_LAST_STEP = 3'(SHIFT_STEPS - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_step;
    logic [13:0] r_sr_sec;
    logic [13:0] r_sr_min;
    logic        w_sample;
    logic        w_shift;
    logic        w_load;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_SAMPLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_SAMPLE: w_state_nxt = S_SHIFT;
            S_SHIFT:  w_state_nxt = (r_step == c_LAST_STEP) ? S_LOAD : S_SHIFT;
            S_LOAD:   w_state_nxt = S_SAMPLE;
            default:  w_state_nxt = S_SAMPLE;
        endcase
    end

    // State decode
    always_comb begin
        w_sample = 1'b0;
        w_shift  = 1'b0;
        w_load   = 1'b0;
        case (r_state)
            S_SAMPLE: w_sample = 1'b1;
            S_SHIFT:  w_shift  = 1'b1;
            S_LOAD:   w_load   = 1'b1;
            default:  w_sample = 1'b0;
        endcase
    end

    // Scratch shift registers; inputs are only looked at in S_SAMPLE, so a
    // change during the shift phase waits for the next conversion.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_step   <= 3'd0;
            r_sr_sec <= 14'd0;
            r_sr_min <= 14'd0;
        end else if (w_sample) begin
            r_step   <= 3'd0;
            r_sr_sec <= {8'd0, i_sec};
            r_sr_min <= {8'd0, i_min};
        end else if (w_shift) begin
            r_step   <= r_step + 3'd1;
            r_sr_sec <= dd_step(r_sr_sec);
            r_sr_min <= dd_step(r_sr_min);
        end
    end

    assign o_load    = w_load;
    assign o_sec_bcd = r_sr_sec[13:6];
    assign o_min_bcd = r_sr_min[13:6];

endmodule
`default_nettype wire

// File: rtl/bcd_display_scan.sv
`default_nettype none
// ============================================================================
// Module      : bcd_display_scan
// Description : Converts mm:ss (two 6-bit binary values) to four BCD digits
//               and time-multiplexes them onto a 4-digit common-anode
//               7-segment display. Decimal point lights on the minutes-units
//               digit as the mm/ss separator.
// Parameters  : SCAN_DIV - clk cycles per digit slot (>= 2)
// Macros      : LEADING_ZERO_BLANK_EN - blank the minutes-tens digit when 0
// Ports       : clk    - rising-edge clock
//               reset  - synchronous active-high reset
//               sec    - seconds 0..63 (binary)
//               min    - minutes 0..63 (binary)
//               an     - digit anodes, active-low one-hot
//               seg    - segments {g,f,e,d,c,b,a}, active-low
//               dp     - decimal point, active-low
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_display_scan
    import bcd_disp_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int             CNT_W      = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic             w_load;
    logic [7:0]       w_sec_bcd;
    logic [7:0]       w_min_bcd;

    logic [CNT_W-1:0] r_scan_cnt;
    logic [1:0]       r_idx;
    logic [3:0]       r_digit     [NUM_DIGITS];
    logic [3:0]       w_digit_nxt [NUM_DIGITS];
    logic             w_wrap;
    logic [1:0]       w_idx_nxt;
    logic [3:0]       w_sel;
    logic [3:0]       r_an;
    logic [6:0]       r_seg;
    logic             r_dp;
    logic [3:0]       w_an_nxt;
    logic [6:0]       w_seg_nxt;
    logic             w_dp_nxt;

    bin2bcd6 u_bin2bcd6 (
        .clk       (clk),
        .reset     (reset),
        .i_sec     (sec),
        .i_min     (min),
        .o_load    (w_load),
        .o_sec_bcd (w_sec_bcd),
        .o_min_bcd (w_min_bcd)
    );

    // Outputs are decoded from the next index and next digits so that an,
    // seg and dp land on the same edge as the index or digit change.
    always_comb begin
        w_wrap    = (r_scan_cnt == c_CNT_LAST);
        w_idx_nxt = w_wrap ? (r_idx + 2'd1) : r_idx;

        w_digit_nxt = r_digit;
        if (w_load) begin
            w_digit_nxt[0] = w_sec_bcd[3:0];
            w_digit_nxt[1] = w_sec_bcd[7:4];
            w_digit_nxt[2] = w_min_bcd[3:0];
            w_digit_nxt[3] = w_min_bcd[7:4];
        end

        w_sel     = w_digit_nxt[w_idx_nxt];
        w_seg_nxt = seg_decode(w_sel);
`ifdef LEADING_ZERO_BLANK_EN
        if ((w_idx_nxt == 2'd3) && (w_digit_nxt[3] == 4'd0)) begin
            w_seg_nxt = c_SEG_BLANK;
        end
`else
`endif
        w_an_nxt = ~(4'b0001 << w_idx_nxt);
        w_dp_nxt = (w_idx_nxt != 2'd2);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_scan_cnt <= '0;
            r_idx      <= 2'd0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_digit[i] <= 4'd0;
            end
            r_an  <= 4'b1110;
            r_seg <= c_SEG_0;
            r_dp  <= 1'b1;
        end else begin
            r_scan_cnt <= w_wrap ? '0 : (r_scan_cnt + 1'b1);
            r_idx      <= w_idx_nxt;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_digit[i] <= w_digit_nxt[i];
            end
            r_an  <= w_an_nxt;
            r_seg <= w_seg_nxt;
            r_dp  <= w_dp_nxt;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule
`default_nettype wire

// File: tb/tb_bcd_display_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_display_scan
// Description : Self-checking bench for bcd_display_scan (SCAN_DIV=4).
//               A reference model pushes the expected digits of each sampled
//               mm:ss pair onto a queue at the sample edge and pops them into
//               its display image at the load edge; every cycle the DUT's
//               an/seg/dp are compared with the model's expected pattern.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_display_scan;

    localparam int SCAN_DIV = 4;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] sec   = 6'd0;
    logic [5:0] min   = 6'd0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bcd_display_scan #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .sec   (sec),
        .min   (min),
        .an    (an),
        .seg   (seg),
        .dp    (dp)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] ref_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0: s = 7'b1000000;
            4'd1: s = 7'b1111001;
            4'd2: s = 7'b0100100;
            4'd3: s = 7'b0110000;
            4'd4: s = 7'b0011001;
            4'd5: s = 7'b0010010;
            4'd6: s = 7'b0000010;
            4'd7: s = 7'b1111000;
            4'd8: s = 7'b0000000;
            4'd9: s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // ---------------- reference model / scoreboard ----------------
    logic [15:0] sb_q[$];
    int          m_phase = 0;   // 0 sample, 1..6 shift, 7 load (cycle phase)
    int          m_cnt   = 0;
    int          m_idx   = 0;
    logic [3:0]  m_dig [4];
    bit          chk_en  = 1'b0;

    always @(posedge clk) begin
        logic [15:0] e;
        if (reset) begin
            m_phase = 0;
            m_cnt   = 0;
            m_idx   = 0;
            for (int i = 0; i < 4; i++) m_dig[i] = 4'd0;
            sb_q.delete();
        end else begin
            if (m_phase == 0) begin
                sb_q.push_back({4'(min / 10), 4'(min % 10), 4'(sec / 10), 4'(sec % 10)});
            end
            if (m_phase == 7) begin
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    m_dig[0] = e[3:0];
                    m_dig[1] = e[7:4];
                    m_dig[2] = e[11:8];
                    m_dig[3] = e[15:12];
                end
            end
            m_phase = (m_phase + 1) % 8;
            if (m_cnt == SCAN_DIV - 1) begin
                m_cnt = 0;
                m_idx = (m_idx + 1) % 4;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_dp;
        if (chk_en) begin
            exp_an  = 4'b1111;
            exp_an[m_idx] = 1'b0;
            exp_seg = ref_seg(m_dig[m_idx]);
`ifdef LEADING_ZERO_BLANK_EN
            if (m_idx == 3 && m_dig[3] == 4'd0) exp_seg = 7'b1111111;
`endif
            exp_dp  = (m_idx == 2) ? 1'b0 : 1'b1;
            check_eq("an",  32'(an),  32'(exp_an));
            check_eq("seg", 32'(seg), 32'(exp_seg));
            check_eq("dp",  32'(dp),  32'(exp_dp));
        end
    end

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_phase(input int p);
        for (int i = 0; i < 16; i++) begin
            if (m_phase == p) return;
            @(negedge clk);
        end
        check_eq("phase_timeout", 32'(m_phase), 32'(p));
    endtask

    task automatic wait_idx(input int p);
        for (int i = 0; i < 16; i++) begin
            if (m_idx == p) return;
            @(negedge clk);
        end
        check_eq("idx_timeout", 32'(m_idx), 32'(p));
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check_eq("rst_an",  32'(an),  32'(4'b1110));
        check_eq("rst_seg", 32'(seg), 32'(7'b1000000));
        check_eq("rst_dp",  32'(dp),  32'(1'b1));

        // 12:45 held: scan through all digits several times
        sec = 6'd45; min = 6'd12;
        reset = 1'b0;
        cycles(20);
        wait_idx(0);
        check_eq("s45_d0_seg", 32'(seg), 32'(7'b0010010));
        wait_idx(2);
        check_eq("m12_d2_dp", 32'(dp), 32'(1'b0));
        cycles(12);

        // Input change on the 2nd shift cycle is deferred one conversion
        sec = 6'd30; min = 6'd0;
        cycles(16);
        wait_phase(2);
        sec = 6'd31;
        cycles(24);

        // Reset pulse mid-conversion
        sec = 6'd59; min = 6'd7;
        cycles(8);
        wait_phase(4);
        reset = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_an",  32'(an),  32'(4'b1110));
        check_eq("mid_rst_seg", 32'(seg), 32'(7'b1000000));
        check_eq("mid_rst_dp",  32'(dp),  32'(1'b1));
        reset = 1'b0;
        cycles(24);

        // Values above 59 display literally
        sec = 6'd63; min = 6'd5;
        cycles(20);
        wait_idx(1);
        check_eq("s63_d1_seg", 32'(seg), 32'(7'b0000010));
        wait_idx(3);
`ifdef LEADING_ZERO_BLANK_EN
        check_eq("m05_d3_seg", 32'(seg), 32'(7'b1111111));
`else
        check_eq("m05_d3_seg", 32'(seg), 32'(7'b1000000));
`endif
        cycles(8);

        // Random values with random hold times
        for (int k = 0; k < 12; k++) begin
            sec = 6'($urandom_range(0, 63));
            min = 6'($urandom_range(0, 63));
            cycles($urandom_range(1, 24));
        end
        cycles(24);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bcd_display_scan.md
BCD_DISPLAY_SCAN -- requirements
Module: bcd_display_scan

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 100000, meaning clk cycles per digit slot (min 2).
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 The ports SHALL be as follows:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous active-high reset.
- sec  in  6  seconds value from the mod-60 counter, binary 0..63.
- min  in  6  minutes value from the mod-60 counter, binary 0..63.
- an  out  4  digit anodes, active-low, one-hot.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.

Function
REQ-004 Conversion FSM states SHALL be S_SAMPLE, S_SHIFT and S_LOAD, and the FSM SHALL free-run.
REQ-005 S_SAMPLE SHALL run for 1 cycle: latch sec and min, clear BCD scratch, go to S_SHIFT.
REQ-006 S_SHIFT SHALL run for exactly 6 cycles of double-dabble, both values in parallel: add 3 to any nibble >=5, then shift left 1.
REQ-007 S_LOAD SHALL run for 1 cycle: write all four display digits at once, then go to S_SAMPLE.
REQ-008 The conversion period SHALL be 8 cycles, and display digits SHALL update on the S_LOAD edge, 8 cycles after sampling.
REQ-009 Inputs changing during S_SHIFT SHALL NOT affect the conversion in flight; the new value SHALL appear after the next S_SAMPLE.
REQ-010 Values 60..63 SHALL display literally (no saturation), e.g. 63 -> 6,3.
REQ-011 Display digits SHALL be d0 = sec units, d1 = sec tens, d2 = min units, d3 = min tens.
REQ-012 The scan counter SHALL count 0..SCAN_DIV-1; at the terminal count it wraps to 0 and the digit index increments mod 4 (3 -> 0).
REQ-013 an SHALL be 1110 for index 0, 1101 for 1, 1011 for 2 and 0111 for 3.
REQ-014 seg SHALL be the active-low decode of the selected digit: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; any other code SHALL give 1111111.
REQ-015 dp SHALL be 0 only while index 2 is selected (separator between minutes and seconds), and 1 otherwise.
REQ-016 an, seg and dp SHALL be registered, changing together on the edge the index changes or a display digit changes.

Reset
REQ-017 Reset SHALL force the following on the next edge, overriding any state or mid-conversion progress:
- FSM to S_SAMPLE.
- Scan counter and index to 0.
- Display digits and scratch to 0.
- an=1110, seg=1000000, dp=1.
REQ-018 The first sample after reset release SHALL occur on the first edge with reset low.

Configuration
REQ-019 Macro LEADING_ZERO_BLANK_EN, when defined, SHALL make seg=1111111 while index 3 is selected and d3==0.
REQ-020 Without LEADING_ZERO_BLANK_EN, d3==0 SHALL display 1000000; all other behaviour is identical.

Structure
REQ-021 Package bcd_disp_pkg SHALL hold:
- the FSM state typedef;
- the seg constants for 0..9 and blank;
- NUM_DIGITS=4;
- SHIFT_STEPS=6.
REQ-022 The double-dabble FSM SHALL be sub-module bin2bcd6, used as one instance converting both 6-bit values; scan, decode and output registers SHALL live in the top module.

Verification
REQ-023 Reset asserted for 1 cycle -> an=1110, seg=1000000, dp=1; FSM in S_SAMPLE.
REQ-024 sec=45, min=12 held, SCAN_DIV=4 -> within 16 cycles digits are 5,4,2,1, and index 0 shows seg=0010010.
REQ-025 SCAN_DIV=4 -> an steps 1110, 1101, 1011, 0111, 1110, each held 4 cycles; dp=0 only during 1011.
REQ-026 sec changed 30 -> 31 on the 2nd S_SHIFT cycle -> next S_LOAD gives 30; the following S_LOAD gives 31.
REQ-027 Reset pulsed on the 4th S_SHIFT cycle with sec=59 -> outputs at reset values next edge; digits reconverted after 8 cycles.
REQ-028 min=5, sec=63 -> digits 3,6,5,0.
REQ-029 Index 3 with LEADING_ZERO_BLANK_EN SHALL give seg=1111111; without it, seg=1000000.
